alu_mc: RTL

Parametrised, multi-cycle successor to the core's 32-bit combinational ALU. It executes the base integer ops in one cycle and the RV32M multiply/divide/remainder ops iteratively, one bit per cycle. It sits in the execute stage behind a valid/ready handshake so the pipeline can stall on long ops and flush in-flight work on a redirect.

---
 rtl/alu_mc.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle XLEN-bit ALU with single-cycle base ops and
//             iterative RV32M multiply/divide behind valid/ready handshakes.
//             Define ALU_MULDIV_EN to build the iterative mul/div datapath.
//  Revision : 1.0 - initial release
// ============================================================================

package types;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SRA = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_AND = 4'd7;
endpackage

module alu_mc
    import types::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [3:0]      alu_op,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_go_busy;
    logic [XLEN-1:0] w_done_res;
    logic            w_done_err;
    logic [XLEN-1:0] w_base_res;
    logic            w_base_err;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] r_result;
    logic            r_err;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign out_err   = r_err;
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_shamt   = operand_b[SHW-1:0];

    always_comb begin
        w_base_res = '0;
        w_base_err = 1'b0;
        case (alu_op)
            ALU_ADD: w_base_res = operand_a + operand_b;
            ALU_SUB: w_base_res = operand_a - operand_b;
            ALU_SLL: w_base_res = operand_a << w_shamt;
            ALU_XOR: w_base_res = operand_a ^ operand_b;
            ALU_SRL: w_base_res = operand_a >> w_shamt;
            ALU_SRA: w_base_res = $unsigned($signed(operand_a) >>> w_shamt);
            ALU_OR:  w_base_res = operand_a | operand_b;
            ALU_AND: w_base_res = operand_a & operand_b;
            default: w_base_err = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam logic [SHW:0] c_last_step = (SHW+1)'(XLEN-1);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mag_b;
    logic [SHW:0]      r_cnt;
    logic [2:0]        r_op;
    logic              r_a_neg;
    logic              r_b_neg;
    logic              r_load;

    logic              w_signed_a;
    logic              w_signed_b;
    logic              w_is_div;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_load_a;
    logic [XLEN-1:0]   w_load_b;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_mul_step;
    logic [2*XLEN-1:0] w_div_step;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_md_final;
    logic              w_busy_last;

    assign w_signed_a = (md_op == 3'b001) || (md_op == 3'b010) ||
                        (md_op == 3'b100) || (md_op == 3'b110);
    assign w_signed_b = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
    assign w_is_div   = md_op[2];
    assign w_b_zero   = (operand_b == '0);
    assign w_ovf      = !md_op[0] && (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (operand_b == '1);
    assign w_special  = w_is_div && (w_b_zero || w_ovf);
    // md_op[1] distinguishes REM/REMU from DIV/DIVU within the divide family
    assign w_special_res = w_b_zero ? (md_op[1] ? operand_a : '1)
                                    : (md_op[1] ? '0 : operand_a);
    assign w_go_busy  = md_en && !w_special;

    assign w_load_a   = r_a_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_load_b   = r_b_neg ? -r_mag_b : r_mag_b;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_b} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_rem_sh - {1'b0, r_mag_b};
    assign w_div_step = w_div_diff[XLEN]
                      ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                      : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    assign w_step     = r_op[2] ? w_div_step : w_mul_step;

    // Sign fix-up folded into the final step so DONE carries the signed value
    assign w_prod     = (r_a_neg ^ r_b_neg) ? -w_step : w_step;
    assign w_quo      = (r_a_neg ^ r_b_neg) ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem      = r_a_neg ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

    always_comb begin
        w_md_final = '0;
        case (r_op)
            3'b000:         w_md_final = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_md_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_md_final = w_quo;
            default:        w_md_final = w_rem;
        endcase
    end

    assign w_busy_last = (r_state == S_BUSY) && !r_load && (r_cnt == c_last_step) && !flush;
    assign w_done_res  = md_en ? w_special_res : w_base_res;
    assign w_done_err  = md_en ? 1'b0 : w_base_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_mag_b <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
            r_load  <= 1'b0;
        end else if (w_accept && w_go_busy) begin
            r_acc   <= {{XLEN{1'b0}}, operand_a};
            r_mag_b <= operand_b;
            r_op    <= md_op;
            r_a_neg <= w_signed_a && operand_a[XLEN-1];
            r_b_neg <= w_signed_b && operand_b[XLEN-1];
            r_cnt   <= '0;
            r_load  <= 1'b1;
        end else if ((r_state == S_BUSY) && !flush) begin
            if (r_load) begin
                r_acc   <= {{XLEN{1'b0}}, w_load_a};
                r_mag_b <= w_load_b;
                r_load  <= 1'b0;
            end else begin
                r_acc <= w_step;
                if (r_cnt != c_last_step) begin
                    r_cnt <= r_cnt + (SHW+1)'(1);
                end
            end
        end
    end
`else
    logic w_unused_md_op;

    assign w_unused_md_op = ^md_op;
    assign w_go_busy      = 1'b0;
    assign w_done_res     = md_en ? '0 : w_base_res;
    assign w_done_err     = md_en ? 1'b1 : w_base_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_go_busy ? S_BUSY : S_DONE;
                end else if ((r_state == S_DONE) && out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                if (w_busy_last) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept && !w_go_busy) begin
            r_result <= w_done_res;
            r_err    <= w_done_err;
        end
`ifdef ALU_MULDIV_EN
        else if (w_busy_last) begin
            r_result <= w_md_final;
            r_err    <= 1'b0;
        end
`endif
    end

endmodule

`default_nettype wire
